// File: rtl/zuart_rx.sv
// zuart_rx: UART receiver, 1 start bit, 8 data bits MSB first, 1 stop bit, idle high.
// Optional macro ZUART_RX_MAJORITY_EN: each sample point takes a 2-of-3 majority
// of three consecutive synchronised samples. The decision is made one clock
// later, so total latency grows by one clock.
module zuart_rx #(
  parameter int CLKS_PER_BIT = 7,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       iClk,
  input  logic       iRstN,
  input  logic       iEn,
  input  logic       iRxEn,
  input  logic       iRxPin,
  output logic [7:0] oRxData,
  output logic       oRxDataValid,
  output logic       oFrameErr
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [7:0] LAST_CNT = 8'(CLKS_PER_BIT - 1);
`ifdef ZUART_RX_MAJORITY_EN
  // Start decision moves one clock later. Later sample points keep the same
  // bit period relative to it, so they shift by one clock as well.
  localparam logic [7:0] START_CNT = 8'(HALF_BIT + 1);
`else
  localparam logic [7:0] START_CNT = 8'(HALF_BIT);
`endif

  state_t     state;
  logic [7:0] cnt;
  logic [2:0] idx;
  logic [7:0] sr;
  logic       sync_q, rx_s, rx_d;
  logic       bit_val;

`ifdef ZUART_RX_MAJORITY_EN
  logic rx_d2;

  // Third tap of the sample history feeding the majority vote
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) rx_d2 <= 1'b1;
    else        rx_d2 <= rx_d;
  end

  // rx_s, rx_d and rx_d2 are three consecutive samples. The vote is taken on the
  // clock after the nominal centre.
  assign bit_val = (rx_s & rx_d) | (rx_s & rx_d2) | (rx_d & rx_d2);
`else
  assign bit_val = rx_s;
`endif

  // Two-flop synchroniser plus one delay tap for edge detection.
  // These flops keep running while the block is disabled.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      sync_q <= 1'b1;
      rx_s   <= 1'b1;
      rx_d   <= 1'b1;
    end else begin
      sync_q <= iRxPin;
      rx_s   <= sync_q;
      rx_d   <= rx_s;
    end
  end

  // Frame FSM: edge hunt, start qualification, data shift, stop check
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state        <= IDLE;
      cnt          <= '0;
      idx          <= '0;
      sr           <= '0;
      oRxData      <= '0;
      oRxDataValid <= 1'b0;
      oFrameErr    <= 1'b0;
    end else begin
      oRxDataValid <= 1'b0;
      oFrameErr    <= 1'b0;
      if (!iEn || !iRxEn) begin
        state <= IDLE;
        cnt   <= '0;
        idx   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (rx_d && !rx_s) begin
              cnt   <= '0;
              state <= START;
            end
          end
          START: begin
            if (cnt == START_CNT) begin
              cnt <= '0;
              idx <= '0;
              // A line that is high again at mid-start was noise, so drop it
              state <= bit_val ? IDLE : DATA;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
          DATA: begin
            if (cnt == LAST_CNT) begin
              sr  <= {sr[6:0], bit_val};
              cnt <= '0;
              idx <= idx + 3'd1;
              if (idx == 3'd7) state <= STOP;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
          STOP: begin
            if (cnt == LAST_CNT) begin
              if (bit_val) begin
                oRxData      <= sr;
                oRxDataValid <= 1'b1;
              end else begin
                oFrameErr <= 1'b1;
              end
              // Leave at mid-stop so a start edge with no idle gap is still seen
              cnt   <= '0;
              state <= IDLE;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_zuart_rx.sv
// tb_zuart_rx: scoreboard bench for zuart_rx. The driver serialises frames and
// pushes the expected byte, error kind and arrival cycle. A monitor pops and
// compares on every output pulse.
module tb_zuart_rx;
  localparam int C = 7;
  localparam int H = C / 2;
`ifdef ZUART_RX_MAJORITY_EN
  localparam bit MAJ = 1'b1;
`else
  localparam bit MAJ = 1'b0;
`endif
  localparam int LAT = 3 + H + 9 * C + (MAJ ? 1 : 0);

  logic       iClk = 1'b0;
  logic       iRstN = 1'b0;
  logic       iEn = 1'b1;
  logic       iRxEn = 1'b1;
  logic       iRxPin = 1'b1;
  logic [7:0] oRxData;
  logic       oRxDataValid;
  logic       oFrameErr;

  zuart_rx #(.CLKS_PER_BIT(C)) dut (
    .iClk(iClk), .iRstN(iRstN), .iEn(iEn), .iRxEn(iRxEn), .iRxPin(iRxPin),
    .oRxData(oRxData), .oRxDataValid(oRxDataValid), .oFrameErr(oFrameErr)
  );

  always #5 iClk = ~iClk;

  int cyc = 0;
  always @(posedge iClk) cyc <= cyc + 1;

  typedef struct {
    bit         ferr;
    logic [7:0] data;
    int         t;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int errors = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge iClk); #1;
      iRxPin = 1'b1;
    end
  endtask

  // Frame index 0 is the start bit, 1..8 are data MSB first, and 9 is the stop bit.
  // If glitch is set, each 0 data bit goes high for one clock at its centre.
  // If abort_bit is 0 or more, one enable drops for one clock inside that frame bit.
  task automatic send(input logic [7:0] b, input bit stop, input bit glitch,
                      input int abort_bit, input bit use_en);
    logic [9:0] fb;
    logic [7:0] ed;
    exp_t       e;
    logic       v;
    fb[0] = 1'b0;
    for (int i = 1; i <= 8; i++) fb[i] = b[8-i];
    fb[9] = stop;
    // Without majority voting, a glitch at the sample point flips a 0 bit to 1
    ed = b;
    if (glitch && !MAJ) ed = 8'hFF;
    for (int k = 0; k < 10; k++) begin
      for (int j = 0; j < C; j++) begin
        @(posedge iClk); #1;
        if (k == 0 && j == 0 && abort_bit < 0) begin
          e.ferr = !stop;
          e.data = ed;
          e.t    = cyc + 1 + LAT;
          q.push_back(e);
        end
        v = fb[k];
        if (glitch && k >= 1 && k <= 8 && !fb[k] && j == H + 1) v = 1'b1;
        iRxPin = v;
        if (k == abort_bit && j == 2) begin
          if (use_en) iEn = 1'b0;
          else        iRxEn = 1'b0;
        end else begin
          iEn   = 1'b1;
          iRxEn = 1'b1;
        end
      end
    end
  endtask

  // Monitor: consume one expectation per output pulse
  initial begin
    logic [7:0] last;
    exp_t       e;
    int         d;
    last = 8'h00;
    forever begin
      @(negedge iClk);
      if (!iRstN) begin
        last = 8'h00;
      end else begin
        if (oRxDataValid && oFrameErr) chk("valid_ferr_exclusive", 1, 0);
        if (oRxDataValid || oFrameErr) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse: got valid=%0b ferr=%0b data=%0h expected none (cycle %0d)",
                     oRxDataValid, oFrameErr, oRxData, cyc);
          end else begin
            e = q.pop_front();
            chk("pulse_kind_ferr", 32'(oFrameErr), 32'(e.ferr));
            if (e.ferr) chk("data_hold_on_ferr", 32'(oRxData), 32'(last));
            else begin
              chk("rx_data", 32'(oRxData), 32'(e.data));
              last = e.data;
            end
            d = cyc - e.t;
            checks++;
            if (d < -1 || d > 1) begin
              errors++;
              $display("FAIL latency: got cycle %0d expected %0d", cyc, e.t);
            end
          end
        end
      end
    end
  end

  initial begin
    // Reset state
    #1;
    chk("reset_data", 32'(oRxData), 0);
    chk("reset_valid", 32'(oRxDataValid), 0);
    chk("reset_ferr", 32'(oFrameErr), 0);
    repeat (3) @(posedge iClk);
    #1 iRstN = 1'b1;
    idle(20);

    // Single frame
    send(8'hA5, 1'b1, 1'b0, -1, 1'b0);
    idle(20);
    // Back-to-back frames with no idle gap
    send(8'h3C, 1'b1, 1'b0, -1, 1'b0);
    send(8'hC3, 1'b1, 1'b0, -1, 1'b0);
    idle(10);
    // False start, then a real frame
    @(posedge iClk); #1 iRxPin = 1'b0;
    @(posedge iClk); #1 iRxPin = 1'b0;
    idle(10);
    send(8'h5A, 1'b1, 1'b0, -1, 1'b0);
    idle(10);
    // Framing error leaves the last good byte in place
    send(8'h11, 1'b1, 1'b0, -1, 1'b0);
    idle(5);
    send(8'hFF, 1'b0, 1'b0, -1, 1'b0);
    idle(10);
    // Abort during data bit 4 (frame index 5) via iRxEn, then via iEn
    send(8'h81, 1'b1, 1'b0, 5, 1'b0);
    idle(20);
    send(8'h7E, 1'b1, 1'b0, -1, 1'b0);
    idle(10);
    send(8'h81, 1'b1, 1'b0, 5, 1'b1);
    idle(20);
    send(8'h42, 1'b1, 1'b0, -1, 1'b0);
    idle(10);
    // Centre glitches on every 0 bit
    send(8'h00, 1'b1, 1'b1, -1, 1'b0);
    idle(10);
    // Break: line held low gives exactly one frame error
    begin
      exp_t e;
      @(posedge iClk); #1;
      e.ferr = 1'b1; e.data = 8'h00; e.t = cyc + 1 + LAT;
      q.push_back(e);
      iRxPin = 1'b0;
      repeat (120) begin @(posedge iClk); #1; iRxPin = 1'b0; end
    end
    idle(10);
    // Asynchronous reset mid-frame clears everything immediately
    for (int k = 0; k < 4 * C; k++) begin
      @(posedge iClk); #1;
      iRxPin = (k < C) ? 1'b0 : k[0];
    end
    #2 iRstN = 1'b0;
    #1;
    chk("midframe_reset_data", 32'(oRxData), 0);
    chk("midframe_reset_valid", 32'(oRxDataValid), 0);
    iRxPin = 1'b1;
    repeat (3) @(posedge iClk);
    #1 iRstN = 1'b1;
    idle(10);
    send(8'h96, 1'b1, 1'b0, -1, 1'b0);
    idle(10);

    // Randomised frames with random gaps and occasional bad stop bits
    for (int n = 0; n < 40; n++) begin
      logic [7:0] b;
      bit         st;
      b  = 8'($urandom);
      st = ($urandom_range(0, 9) != 0);
      send(b, st, 1'b0, -1, 1'b0);
      idle(st ? $urandom_range(0, 3) : $urandom_range(2, 4));
    end

    idle(100);
    chk("scoreboard_drained", 32'(q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/zuart_rx.md
Name: zuart_rx

Overview:
UART receiver for the link partner of the on-chip UART transmitter. Deserialises 1 start bit, 8 data bits sent MSB first, and 1 stop bit, with the line idling high. Sits beside the transmitter in the UART controller and shares its common enable. Delivers each received byte to the fabric with a one-cycle valid strobe and flags bad stop bits.

Parameters:
CLKS_PER_BIT, 7, iClk cycles per UART bit period; must equal the transmitter's bit period of 7 clocks at 24 MHz. Legal range 4..255.
HALF_BIT, CLKS_PER_BIT/2 (integer), offset from the detected start edge to the start-bit sample point. Default value is 3.

Ports:
iClk  input  1  system clock, 24 MHz
iRstN  input  1  reset, asynchronous, active-low
iEn  input  1  block enable. Low forces IDLE.
iRxEn  input  1  receive enable. Low forces IDLE.
iRxPin  input  1  physical serial input, asynchronous, idle high
oRxData  output  8  last correctly framed byte
oRxDataValid  output  1  one-cycle pulse when oRxData updates
oFrameErr  output  1  one-cycle pulse when the stop bit is sampled low

Behaviour:
- Reset values: oRxData=8'h00, oRxDataValid=0, oFrameErr=0, FSM=IDLE, counters=0, synchroniser flops=1.
- Synchroniser: iRxPin passes through a 2-flop synchroniser to rx_s. rx_d is rx_s delayed by one clock, used for edge detection. All decisions use rx_s.
- Bit counter cnt is 8 bits wide. Bit index idx is 3 bits wide. The shift register sr is 8 bits wide.
- IDLE: when rx_d=1 and rx_s=0 (falling edge), clear cnt and go to START.
- START: cnt increments each clock. At cnt==HALF_BIT:
  - if rx_s=0, clear cnt and idx, then go to DATA;
  - if rx_s=1, treat it as a false start and return to IDLE with no output.
- DATA: cnt counts 0..CLKS_PER_BIT-1. At cnt==CLKS_PER_BIT-1, sample rx_s: sr<={sr[6:0],rx_s} (MSB first), clear cnt, increment idx. After the 8th sample (idx wraps from 7 to 0), go to STOP.
- STOP: at cnt==CLKS_PER_BIT-1, sample rx_s.
  - If 1: oRxData<=sr and oRxDataValid=1 for exactly the next cycle.
  - If 0: oFrameErr=1 for one cycle; oRxData is unchanged.
  - In both cases return to IDLE at the stop-bit midpoint, so a start edge on the following cycle is accepted. Back-to-back frames with no idle gap are supported.
- Latency: oRxDataValid rises 3+HALF_BIT+9*CLKS_PER_BIT clocks after the iRxPin falling edge, ±1 clock of synchroniser uncertainty. At default parameters this is 69 clocks.
- oRxDataValid and oFrameErr are mutually exclusive and never assert for more than one cycle.
- iEn=0 or iRxEn=0, at any time including mid-frame:
  - next clock: FSM=IDLE, cnt=0, idx=0, oRxDataValid=0, oFrameErr=0;
  - oRxData holds its value and no partial byte is delivered;
  - the synchroniser keeps running, so re-enabling while the line is low does not create a false edge.
- Asynchronous reset mid-frame immediately restores all reset values.
- A line that stays low continuously (break condition) produces one frame error, then waits in IDLE for the next high-to-low edge.

Optional Feature:
ZUART_RX_MAJORITY_EN:
- Defined: every sample point (start, data and stop) takes a 2-of-3 majority of rx_s at cnt==target-1, target and target+1. The decision and shift happen at target+1, and all later timing shifts by 1 clock, so latency grows by 1 clock. Requires CLKS_PER_BIT>=5.
- Undefined: a single sample of rx_s at the target cycle, as described above.

Test Plan:
- Single frame: drive 0xA5 MSB first at 7 clocks/bit, with 20 idle clocks before and after -> one oRxDataValid pulse with oRxData=0xA5, and oFrameErr stays 0.
- Back-to-back: send 0x3C then 0xC3 with no idle gap -> two valid pulses with 0x3C then 0xC3, pulses 70 clocks apart.
- False start: pull iRxPin low for 2 clocks, then high -> no valid and no error; a following 0x5A is received correctly.
- Framing error: receive 0x11, then send 0xFF with the stop bit held low -> oFrameErr pulses once, no valid pulse, and oRxData stays 0x11.
- Abort: drop iRxEn for 1 clock during bit 4 of 0x81 -> no output for that frame; the next frame 0x7E yields oRxData=0x7E.
- Majority (macro defined): a 1-clock high glitch at the centre of each 0-bit of 0x00 -> oRxData=0x00. With the macro undefined, the same stimulus corrupts the byte.
